// File: rtl/if_id_skid_reg.sv
// Elastic IF/ID pipeline register: a 2-entry skid buffer carrying PC and instruction
// from fetch to decode. It supports flush and presents a NOP bubble while empty.
module if_id_skid_reg #(
  parameter int             N         = 32,
  parameter logic [N-1:0]   NOP_INSTR = N'(32'h00000013),
  parameter logic [N-1:0]   PC_IDLE   = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] pc_in,
  input  logic [N-1:0] instr_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pc_out,
  output logic [N-1:0] instr_out,
  output logic [1:0]   occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_reg;
  logic [N-1:0] main_pc_reg;
  logic [N-1:0] main_instr_reg;
  logic [N-1:0] skid_pc_reg;
  logic [N-1:0] skid_instr_reg;

  logic acc;
  logic dlv;

  // Handshake outputs come straight from the state register, so decode's
  // out_ready never reaches in_ready through combinational logic.
  assign out_valid = (state_reg != EMPTY);
  assign in_ready  = (state_reg != FULL);
  assign occupancy = state_reg;
  assign pc_out    = main_pc_reg;
  assign instr_out = main_instr_reg;

  assign acc = in_valid & in_ready;
  assign dlv = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= EMPTY;
      main_pc_reg    <= PC_IDLE;
      main_instr_reg <= NOP_INSTR;
      skid_pc_reg    <= PC_IDLE;
      skid_instr_reg <= NOP_INSTR;
    end else if (flush) begin
      // A same-edge accept is dropped. A same-edge delivery has already been
      // taken by decode, so clearing both entries loses nothing.
      state_reg      <= EMPTY;
      main_pc_reg    <= PC_IDLE;
      main_instr_reg <= NOP_INSTR;
      skid_pc_reg    <= PC_IDLE;
      skid_instr_reg <= NOP_INSTR;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (acc) begin
            main_pc_reg    <= pc_in;
            main_instr_reg <= instr_in;
            state_reg      <= ONE;
          end
        end
        ONE: begin
          case ({acc, dlv})
            2'b10: begin
              skid_pc_reg    <= pc_in;
              skid_instr_reg <= instr_in;
              state_reg      <= FULL;
            end
            2'b11: begin
              main_pc_reg    <= pc_in;
              main_instr_reg <= instr_in;
            end
            2'b01: begin
              main_pc_reg    <= PC_IDLE;
              main_instr_reg <= NOP_INSTR;
              state_reg      <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (dlv) begin
            main_pc_reg    <= skid_pc_reg;
            main_instr_reg <= skid_instr_reg;
            skid_pc_reg    <= PC_IDLE;
            skid_instr_reg <= NOP_INSTR;
            state_reg      <= ONE;
          end
        end
        default: begin
          // The unused encoding falls back to a clean empty buffer.
          state_reg      <= EMPTY;
          main_pc_reg    <= PC_IDLE;
          main_instr_reg <= NOP_INSTR;
          skid_pc_reg    <= PC_IDLE;
          skid_instr_reg <= NOP_INSTR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed and random checks of if_id_skid_reg against a queue-based FIFO model.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [1:0]  occupancy;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  int   checks;
  int   errors;

  if_id_skid_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every output follows from the model queue alone.
  task automatic check_outputs(input string tag);
    int n;
    n = q.size();
    check({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
    check({tag, ".in_ready"},  64'(in_ready),  64'(n != 2));
    check({tag, ".occupancy"}, 64'(occupancy), 64'(n));
    check({tag, ".pc_out"},    64'(pc_out),    (n != 0) ? 64'(q[0].pc)    : 64'd0);
    check({tag, ".instr_out"}, 64'(instr_out), (n != 0) ? 64'(q[0].instr) : 64'(NOP));
  endtask

  // One clock: drive inputs, step the model at the edge, then compare.
  task automatic cycle(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy, input string tag);
    logic a;
    logic d;
    flush     = fl;
    in_valid  = iv;
    pc_in     = pc;
    instr_in  = ins;
    out_ready = ordy;
    a = iv && (q.size() < 2);
    d = ordy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (d) void'(q.pop_front());
      if (a) q.push_back('{pc: pc, instr: ins});
    end
    check_outputs(tag);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pc_in     = '0;
    instr_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("post_reset");

    // Asynchronous reset mid-cycle while FULL.
    $display("reset: fill to FULL then assert rst_n mid-cycle");
    cycle(0, 1, 32'h100, 32'hAAAA0001, 0, "fill0");
    cycle(0, 1, 32'h104, 32'hAAAA0002, 0, "fill1");
    check("fill.occupancy", 64'(occupancy), 64'd2);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.occupancy", 64'(occupancy), 64'd0);
    check("rst.instr_out", 64'(instr_out), 64'h13);
    check("rst.pc_out",    64'(pc_out),    64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release must accept.
    cycle(0, 1, 32'h200, 32'hBEEF0000, 0, "first_acc");
    check("first_acc.pc", 64'(pc_out), 64'h200);
    cycle(0, 0, 32'h0, 32'h0, 1, "drain0");

    // Streaming at full rate.
    $display("stream: pcs 0x0 0x4 0x8");
    cycle(0, 1, 32'h0, 32'hA, 1, "s0");
    check("s0.pc", 64'(pc_out), 64'h0);
    check("s0.instr", 64'(instr_out), 64'hA);
    cycle(0, 1, 32'h4, 32'hB, 1, "s1");
    check("s1.pc", 64'(pc_out), 64'h4);
    check("s1.occ", 64'(occupancy), 64'd1);
    cycle(0, 1, 32'h8, 32'hC, 1, "s2");
    check("s2.instr", 64'(instr_out), 64'hC);
    check("s2.in_ready", 64'(in_ready), 64'd1);
    cycle(0, 0, 32'h0, 32'h0, 1, "s3");
    check("s3.out_valid", 64'(out_valid), 64'd0);

    // Stall builds up two entries; inputs ignored while full.
    $display("stall: 0x10 0x14 with out_ready low");
    cycle(0, 1, 32'h10, 32'hD, 0, "st0");
    cycle(0, 1, 32'h14, 32'hE, 0, "st1");
    check("st1.occ", 64'(occupancy), 64'd2);
    check("st1.in_ready", 64'(in_ready), 64'd0);
    check("st1.pc", 64'(pc_out), 64'h10);
    cycle(0, 1, 32'h99, 32'hF, 0, "st2");
    check("st2.pc_held", 64'(pc_out), 64'h10);
    cycle(0, 0, 32'h0, 32'h0, 1, "st3");
    check("st3.pc", 64'(pc_out), 64'h14);
    check("st3.instr", 64'(instr_out), 64'hE);
    cycle(0, 0, 32'h0, 32'h0, 1, "st4");
    check("st4.occ", 64'(occupancy), 64'd0);

    // Flush while FULL with a same-edge offer of 0x18.
    $display("flush: FULL with in_valid pc 0x18");
    cycle(0, 1, 32'h20, 32'h20, 0, "f0");
    cycle(0, 1, 32'h24, 32'h24, 0, "f1");
    cycle(1, 1, 32'h18, 32'h18, 0, "f2");
    check("f2.occ", 64'(occupancy), 64'd0);
    check("f2.out_valid", 64'(out_valid), 64'd0);
    check("f2.instr", 64'(instr_out), 64'h13);
    check("f2.in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 32'h0, 32'h0, 1, "f_after");
      check("f_after.no_0x18", 64'(out_valid), 64'd0);
    end

    // Flush coincident with delivery in ONE.
    $display("flush: coincident with delivery in ONE");
    cycle(0, 1, 32'h30, 32'h30, 0, "fd0");
    check("fd0.pc", 64'(pc_out), 64'h30);
    cycle(1, 0, 32'h0, 32'h0, 1, "fd1");
    check("fd1.occ", 64'(occupancy), 64'd0);
    check("fd1.pc", 64'(pc_out), 64'h0);

    // Random traffic against the queue model.
    $display("random: 10000 cycles");
    begin
      logic [31:0] next_pc;
      next_pc = 32'h1000;
      for (int i = 0; i < 10000; i++) begin
        logic iv;
        logic ordy;
        logic fl;
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
        fl   = ($urandom_range(0, 63) == 0);
        cycle(fl, iv, next_pc, $urandom, ordy, "rnd");
        if (iv && !fl && in_ready !== 1'bx) next_pc = next_pc + 32'd4;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
